// File: rtl/uart_receiver.sv
// uart_receiver
// -------------
// Receive side of the UART link. Recovers frames of 1 start bit, 8 data bits
// (LSB first), an optional even parity bit and 1 or 2 stop bits from an
// asynchronous serial line. Every received byte is offered through a
// valid/ack handshake together with its parity and framing error flags.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   uart_rx      asynchronous serial input, idle high
//   baudrate     clock cycles per bit; values below 4 behave as 4
//   stop         0/1 -> one stop bit, 2/3 -> two stop bits
//   parity_en    1 = an even parity bit follows the data bits
//   rx_data      received byte
//   rx_valid     rx_data holds a byte the consumer has not yet taken
//   rx_ack       consumer takes rx_data (ignored while rx_valid is low)
//   parity_err   parity mismatch on the byte in rx_data
//   frame_err    a stop bit of the byte in rx_data was sampled low
//   overrun_err  one-cycle pulse: a byte replaced one that was never acked
//   busy         receiver is anywhere other than idle
//
// Configuration is captured when the start edge is seen, so it may change
// freely while a frame is in flight.

module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic [15:0] baudrate,
    input  logic [1:0]  stop,
    input  logic        parity_en,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun_err,
    output logic        busy
);

    // A single flop gives no metastability protection, so never go below two.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DELIVER,
        S_BREAK
    } state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] sync_q, sync_d;
    logic              rx_prev_q, rx_prev_d;
    logic [15:0]       div_q, div_d;
    logic [15:0]       bit_q, bit_d;
    logic [15:0]       baud_q, baud_d;
    logic              two_stop_q, two_stop_d;
    logic              par_en_q, par_en_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic              frm_bad_q, frm_bad_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              rx_s;
    logic              start_det;
    logic              sample;
    logic              deliver;
    logic [15:0]       baud_eff;
    logic [15:0]       last_stop;

    assign rx_s      = sync_q[STAGES-1];
    assign sync_d    = {sync_q[STAGES-2:0], uart_rx};
    assign rx_prev_d = rx_s;

    // A start edge is a high-to-low transition of the synchronized line.
    // Because rx_prev_q only goes high after the line has been high for a
    // cycle, a line that stays low after BREAK can never look like a start.
    assign start_det = rx_prev_q & ~rx_s;

    assign sample    = (div_q == 16'd0);
    assign baud_eff  = (baudrate < 16'd4) ? 16'd4 : baudrate;
    assign last_stop = two_stop_q ? 16'd1 : 16'd0;

    // Frame sequencer. The divider is loaded with floor(N/2)-1 on the start
    // edge so the first sample lands mid start bit, then reloaded with N-1 at
    // every sample so later samples are exactly N cycles apart.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        baud_d     = baud_q;
        two_stop_d = two_stop_q;
        par_en_d   = par_en_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        frm_bad_d  = frm_bad_q;
        deliver    = 1'b0;

        if (state_q == S_START || state_q == S_DATA ||
            state_q == S_PARITY || state_q == S_STOP) begin
            div_d = sample ? (baud_q - 16'd1) : (div_q - 16'd1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d    = S_START;
                    baud_d     = baud_eff;
                    two_stop_d = (stop >= 2'd2);
                    par_en_d   = parity_en;
                    div_d      = (baud_eff >> 1) - 16'd1;
                    bit_d      = 16'd0;
                    par_bad_d  = 1'b0;
                    frm_bad_d  = 1'b0;
                end
            end
            S_START: begin
                if (sample) begin
                    state_d = rx_s ? S_IDLE : S_DATA;
                    bit_d   = 16'd0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 16'd1;
                    if (bit_q == 16'd7) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        bit_d   = 16'd0;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_bad_d = (^shift_q) ^ rx_s;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    frm_bad_d = frm_bad_q | ~rx_s;
                    bit_d     = bit_q + 16'd1;
                    if (bit_q == last_stop) begin
                        state_d = S_DELIVER;
                        deliver = 1'b1;
                    end
                end
            end
            S_DELIVER: begin
                state_d = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output handshake. The byte is registered on the edge that enters
    // DELIVER, so rx_valid is already high during the DELIVER cycle, one
    // cycle after the last stop sample. An ack on that same edge retires the
    // old byte, so the new one is accepted cleanly without an overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ack) begin
            rx_valid_d   = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
        end

        if (deliver) begin
            rx_data_d    = shift_q;
            rx_valid_d   = 1'b1;
            parity_err_d = par_bad_q;
            frame_err_d  = frm_bad_q | ~rx_s;
            overrun_d    = rx_valid_q & ~rx_ack;
        end
    end

    // State register. The synchronizer and edge detector reset to the idle
    // line level so a reset never manufactures a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            div_q        <= 16'd0;
            bit_q        <= 16'd0;
            baud_q       <= 16'd4;
            two_stop_q   <= 1'b0;
            par_en_q     <= 1'b0;
            shift_q      <= 8'h00;
            par_bad_q    <= 1'b0;
            frm_bad_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rx_prev_q    <= rx_prev_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            baud_q       <= baud_d;
            two_stop_q   <= two_stop_d;
            par_en_q     <= par_en_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frm_bad_q    <= frm_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps

module tb_uart_receiver;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        uart_rx   = 1'b1;
    logic [15:0] baudrate  = 16'd16;
    logic [1:0]  stop      = 2'd0;
    logic        parity_en = 1'b0;
    logic        rx_ack    = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;

    always #5 clk = ~clk;

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .baudrate    (baudrate),
        .stop        (stop),
        .parity_en   (parity_en),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    // Posedge counter; after posedge number k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int         cycle;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] got_q[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_perr  = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ack   = 1'b0;
    logic       old_valid;
    logic       exp_ovr;
    logic       prev_dut_valid = 1'b0;
    int         dut_rise   = -1;
    int         ovr_pulses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Serial transmitter model: drives one whole frame, one bit per n cycles,
    // and records when and what the receiver must deliver. The byte must
    // appear two synchronizer cycles plus half a bit plus one bit period per
    // later sample after the start bit, and one cycle after the final sample.
    task automatic applyStimulus(input logic [7:0] data, input int baud, input logic [1:0] stop_code,
                                 input logic par, input logic par_bit, input logic [1:0] stop_vals,
                                 input logic scramble);
        int   n;
        int   nstop;
        exp_t e;
        n        = (baud < 4) ? 4 : baud;
        nstop    = (stop_code >= 2'd2) ? 2 : 1;
        e.cycle  = cyc + 3 + n / 2 + (8 + int'(par) + nstop) * n;
        e.data   = data;
        e.perr   = par && (((^data) ^ par_bit) != 1'b0);
        e.ferr   = (stop_vals[0] == 1'b0) || (nstop == 2 && stop_vals[1] == 1'b0);
        exp_q.push_back(e);
        baudrate  = 16'(baud);
        stop      = stop_code;
        parity_en = par;
        uart_rx   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        if (scramble) begin
            baudrate  = 16'(baud + 5);
            stop      = ~stop_code;
            parity_en = ~par;
        end
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (n) @(posedge clk);
            #1;
        end
        if (par) begin
            uart_rx = par_bit;
            repeat (n) @(posedge clk);
            #1;
        end
        for (int i = 0; i < nstop; i++) begin
            uart_rx = stop_vals[i];
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic ackOnce();
        rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Scoreboard: keeps the consumer-visible state (valid byte, flags) from
    // the expected deliveries and the acks the bench issued, and compares the
    // DUT against it every cycle.
    always @(negedge clk) begin
        if (reset) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_ack   = 1'b0;
            exp_q.delete();
            prev_dut_valid = 1'b0;
        end else begin
            old_valid = m_valid;
            exp_ovr   = 1'b0;
            if (m_valid && m_ack) begin
                m_valid = 1'b0;
                m_perr  = 1'b0;
                m_ferr  = 1'b0;
            end
            if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
                exp_ovr = old_valid && !m_ack;
                m_valid = 1'b1;
                m_data  = exp_q[0].data;
                m_perr  = exp_q[0].perr;
                m_ferr  = exp_q[0].ferr;
                void'(exp_q.pop_front());
            end
            checkOutput("rx_valid", 32'(rx_valid), 32'(m_valid));
            checkOutput("overrun_err", 32'(overrun_err), 32'(exp_ovr));
            if (m_valid) begin
                checkOutput("rx_data", 32'(rx_data), 32'(m_data));
                checkOutput("parity_err", 32'(parity_err), 32'(m_perr));
                checkOutput("frame_err", 32'(frame_err), 32'(m_ferr));
            end else begin
                checkOutput("parity_err_idle", 32'(parity_err), 32'd0);
                checkOutput("frame_err_idle", 32'(frame_err), 32'd0);
            end
            if (rx_valid && !prev_dut_valid) begin
                dut_rise = cyc;
                got_q.push_back(rx_data);
            end
            if (overrun_err) ovr_pulses++;
            prev_dut_valid = rx_valid;
            m_ack = rx_ack;
        end
    end

    logic [7:0] lb [3] = '{8'h00, 8'hFF, 8'h55};

    initial begin
        int c0;
        int p0;
        int r0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun_err), 32'd0);

        // 0xA5, 16 cycles/bit, one stop, no parity: D+153 plus two sync cycles.
        c0 = cyc;
        applyStimulus(8'hA5, 16, 2'd1, 1'b0, 1'b0, 2'b11, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("a5_latency", 32'(dut_rise - c0), 32'd155);
        checkOutput("a5_data", 32'(rx_data), 32'hA5);
        checkOutput("a5_perr", 32'(parity_err), 32'd0);
        checkOutput("a5_ferr", 32'(frame_err), 32'd0);
        checkOutput("a5_busy_after", 32'(busy), 32'd0);
        ackOnce();

        // Even parity on 0x03: correct bit is 0, then a wrong bit 1.
        applyStimulus(8'h03, 16, 2'd0, 1'b1, 1'b0, 2'b11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("par_ok_data", 32'(rx_data), 32'h03);
        checkOutput("par_ok_perr", 32'(parity_err), 32'd0);
        ackOnce();
        applyStimulus(8'h03, 16, 2'd0, 1'b1, 1'b1, 2'b11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("par_bad_perr", 32'(parity_err), 32'd1);
        ackOnce();

        // Two stop bits, second one low, then the line stays low (break).
        applyStimulus(8'h5A, 16, 2'd2, 1'b0, 1'b0, 2'b01, 1'b0);
        checkOutput("brk_ferr", 32'(frame_err), 32'd1);
        checkOutput("brk_data", 32'(rx_data), 32'h5A);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("brk_busy_held", 32'(busy), 32'd1);
        uart_rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("brk_busy_released", 32'(busy), 32'd0);
        ackOnce();

        // Five-cycle glitch is rejected at the mid start-bit sample.
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 uart_rx = 1'b1;
        checkOutput("glitch_busy_start", 32'(busy), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("glitch_busy_end", 32'(busy), 32'd0);
        checkOutput("glitch_no_valid", 32'(rx_valid), 32'd0);

        // Overrun: two bytes without an ack in between.
        p0 = ovr_pulses;
        applyStimulus(8'h11, 16, 2'd0, 1'b0, 1'b0, 2'b11, 1'b0);
        applyStimulus(8'h22, 16, 2'd0, 1'b0, 1'b0, 2'b11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ovr_pulses", 32'(ovr_pulses - p0), 32'd1);
        checkOutput("ovr_data", 32'(rx_data), 32'h22);
        checkOutput("ovr_valid", 32'(rx_valid), 32'd1);
        ackOnce();
        checkOutput("ovr_ack_clears", 32'(rx_valid), 32'd0);

        // Ack arriving on the very edge a new byte is loaded: no overrun.
        applyStimulus(8'h33, 16, 2'd0, 1'b0, 1'b0, 2'b11, 1'b0);
        p0 = ovr_pulses;
        fork
            applyStimulus(8'h44, 16, 2'd0, 1'b0, 1'b0, 2'b11, 1'b0);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checkOutput("simul_no_ovr", 32'(ovr_pulses - p0), 32'd0);
        checkOutput("simul_data", 32'(rx_data), 32'h44);
        checkOutput("simul_valid", 32'(rx_valid), 32'd1);
        ackOnce();

        // Baudrate below the minimum runs at 4 cycles per bit.
        applyStimulus(8'h96, 2, 2'd0, 1'b0, 1'b0, 2'b11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("slow_clamp_data", 32'(rx_data), 32'h96);
        ackOnce();

        // Configuration changed right after the start bit must be ignored.
        applyStimulus(8'hC3, 8, 2'd0, 1'b1, 1'b0, 2'b11, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cfg_latch_data", 32'(rx_data), 32'hC3);
        checkOutput("cfg_latch_perr", 32'(parity_err), 32'd0);
        ackOnce();

        // Back-to-back frames across all stop/parity encodings, consumer
        // acking continuously.
        got_q.delete();
        rx_ack = 1'b1;
        for (int sc = 0; sc < 4; sc++) begin
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 3; b++) begin
                    applyStimulus(lb[b], 4, 2'(sc), p[0], ^lb[b], 2'b11, 1'b0);
                end
            end
        end
        for (int b = 0; b < 3; b++) begin
            applyStimulus(lb[b], 868, 2'd3, 1'b1, ^lb[b], 2'b11, 1'b0);
        end
        repeat (5) @(posedge clk);
        #1 rx_ack = 1'b0;
        checkOutput("loop_count", 32'(got_q.size()), 32'd27);
        for (int i = 0; i < got_q.size() && i < 27; i++) begin
            checkOutput("loop_order", 32'(got_q[i]), 32'(lb[i % 3]));
        end

        // Reset in the middle of a frame: nothing is delivered.
        r0 = dut_rise;
        uart_rx = 1'b0;
        repeat (16) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (16) @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (16) @(posedge clk);
        #1 uart_rx = 1'b1;
        doReset();
        repeat (200) @(posedge clk);
        #1;
        checkOutput("midreset_no_rise", 32'(dut_rise), 32'(r0));
        checkOutput("midreset_valid", 32'(rx_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);

        applyStimulus(8'h7E, 16, 2'd0, 1'b0, 1'b0, 2'b11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("recover_data", 32'(rx_data), 32'h7E);
        ackOnce();

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side companion to the UART transmitter. Consumes the serial line the transmitter drives (uart_tx, looped back or from the pad) and recovers frames.
- Frame format: 1 start bit, 8 data bits LSB-first, optional even parity, 1–2 stop bits.
- Uses the same configuration encoding as the transmitter (baudrate, stop, parity_en), so a TX→RX loopback works with identical settings.
- Delivers each byte with a valid/ack handshake and per-frame error flags.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the uart_rx input synchronizer (min 2); the synchronizer resets to 1 (idle).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- uart_rx  input  1  asynchronous serial line, idle high
- baudrate  input  16  clock cycles per bit (same encoding as transmitter); values <4 treated as 4
- stop  input  2  stop bits: 0 or 1 → one stop bit; 2 or 3 → two stop bits
- parity_en  input  1  1 = even parity bit follows data
- rx_data  output  8  received byte
- rx_valid  output  1  rx_data holds an unread byte
- rx_ack  input  1  consumer accepts rx_data
- parity_err  output  1  parity mismatch on the byte in rx_data
- frame_err  output  1  a stop bit sampled low on the byte in rx_data
- overrun_err  output  1  one-cycle pulse: a frame completed while rx_valid was still high
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0 (rx_data 8'h00); state IDLE; counters cleared. Reset mid-frame aborts the frame with no rx_valid.
- Config (baudrate, stop, parity_en) is latched at start detection. Changes mid-frame have no effect on that frame.
- Start detection cycle D: the synchronized line is 0 and was 1 in the previous cycle.
- Sample points:
  - First sample at D + floor(N/2), where N is the latched baudrate.
  - Each later sample exactly N cycles after the previous one.
  - Bit counter and divider counter use full 16-bit arithmetic; no wrap inside a frame.
- States:
  - IDLE: on start detection → START.
  - START: at the mid-bit sample, line 0 → DATA. Line 1 → IDLE (glitch rejected, no flags, no valid).
  - DATA: 8 samples shifted in LSB-first, then → PARITY if parity_en else → STOP.
  - PARITY: sample the parity bit; error if data XOR-reduce XOR parity bit ≠ 0. Then → STOP.
  - STOP: 1 or 2 samples; any 0 sample sets the frame error. After the last sample → DELIVER.
  - DELIVER (1 cycle):
    - Load rx_data, parity_err, frame_err; set rx_valid.
    - If rx_valid was already high and not acked this cycle: overwrite the old byte and pulse overrun_err for this cycle.
    - → IDLE if the line is 1, else → BREAK.
  - BREAK: wait until the synchronized line is 1, then → IDLE. No start detection occurs until the line has been high for ≥1 cycle.
- Latency: rx_valid rises exactly 1 cycle after the final stop sample.
- Handshake:
  - rx_valid stays high until a cycle with rx_ack=1; it clears on the next edge. rx_data and the error flags hold while rx_valid is high.
  - rx_ack with rx_valid=0 is ignored.
  - Simultaneous DELIVER and rx_ack: the new byte is loaded, rx_valid stays 1, and there is no overrun.
- Error flags are cleared together with rx_valid on ack.

Test Plan:
- baudrate=16, stop=1, parity_en=0; drive 0xA5 frame → rx_valid high at D+8+9·16+1 = D+153; rx_data=8'hA5; parity_err=frame_err=0; busy low after.
- baudrate=16, parity_en=1; send 0x03 with parity bit 0 → rx_data=8'h03, parity_err=0. Resend with parity bit 1 → parity_err=1.
- stop=2; send 0x5A with second stop bit driven 0 → frame_err=1; line held low 40 cycles after → FSM stays in BREAK, no new frame until line returns high.
- Glitch: line low for 5 cycles at baudrate=16 → no rx_valid, busy returns 0 after the START sample, no flags.
- Overrun: receive 0x11 without ack, then 0x22 → overrun_err pulses for 1 cycle, rx_data=8'h22, rx_valid stays 1. Assert rx_ack → rx_valid=0 next cycle.
- Loopback: connect the transmitter's uart_tx to uart_rx with identical config (baudrate=4 and baudrate=868, all stop/parity combos); send 0x00, 0xFF, 0x55 → bytes received in order, no errors; a reset asserted mid-frame yields no delivery.
